// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_DEPTH   = 64;
    localparam int unsigned DEF_LATENCY = 2;

    function automatic int unsigned addr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Counter only ever holds LATENCY-2, so size it for that value.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat > 2) ? $clog2(lat - 1) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, registered read, no storage reset.
module dmem_array #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          we,
    input  logic          clr,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read register holds between accesses; clr forces a zero response.
    always_comb begin
        rdata_d = rdata_q;
        if (clr) begin
            rdata_d = '0;
        end else if (en && !we) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Latency-modelling responder for the data-memory port: one access at a time,
// done pulse on completion, misaligned accesses flagged and suppressed.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned AW = addr_width(DEPTH);
    localparam int unsigned CW = cnt_width(LATENCY);
    localparam logic [CW-1:0] CNT_INIT =
        (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;

    logic          go_done;
    logic          acc_we;
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic          aligned;
    logic          unused_addr;

    assign unused_addr = ^addr;

    // With LATENCY==1 the access completes on the accept edge itself,
    // before the request latch has captured anything.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we    = we;
            acc_addr  = addr[AW+1:0];
            acc_wdata = wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    assign aligned = (acc_addr[1:0] == 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        go_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr[AW+1:0];
                    wdata_d = wdata;
                    if (LATENCY == 1) begin
                        state_d = ST_DONE;
                        go_done = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    go_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        err_d = go_done ? !aligned : err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rst_n (reset),
        .en    (go_done && aligned && reset),
        .we    (acc_we),
        .clr   (go_done && !aligned),
        .addr  (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .rdata (rdata)
    );

    assign ready = (state_q == ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: LATENCY 2 vector table, reset abort, LATENCY 3
// back-to-back handshake and LATENCY 1 timing.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic req2 = 0, we2 = 0, ready2, done2, err2;
    logic [31:0] addr2 = 0, wdata2 = 0, rdata2;
    logic req3 = 0, we3 = 0, ready3, done3, err3;
    logic [31:0] addr3 = 0, wdata3 = 0, rdata3;
    logic req1 = 0, we1 = 0, ready1, done1, err1;
    logic [31:0] addr1 = 0, wdata1 = 0, rdata1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(64), .LATENCY(2)) u_d2 (
        .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2),
        .wdata(wdata2), .ready(ready2), .done(done2), .rdata(rdata2),
        .err(err2)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(3)) u_d3 (
        .clk(clk), .reset(reset), .req(req3), .we(we3), .addr(addr3),
        .wdata(wdata3), .ready(ready3), .done(done3), .rdata(rdata3),
        .err(err3)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(1)) u_d1 (
        .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1),
        .wdata(wdata1), .ready(ready1), .done(done1), .rdata(rdata1),
        .err(err1)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One access on the LATENCY=2 instance; lat counts negedge samples
    // from the accept edge to the first sample with done high.
    task automatic access2(input logic w, input logic [31:0] a,
                           input logic [31:0] d, output int lat,
                           output logic e, output logic [31:0] rd);
        @(negedge clk);
        chk("ready_idle", ready2, 1);
        req2 = 1; we2 = w; addr2 = a; wdata2 = d;
        lat = 0;
        e = 0;
        rd = 0;
        while (lat < 20) begin
            @(negedge clk);
            req2 = 0;
            lat++;
            chk("ready_busy", ready2, 0);
            if (done2) break;
        end
        e = err2;
        rd = rdata2;
        @(negedge clk);
        chk("done_pulse_end", done2, 0);
        chk("ready_back", ready2, 1);
    endtask

    int lat;
    logic e;
    logic [31:0] rd;
    int ndone;

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0008, 32'h1234_5678, 1'b0, 1'b1, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0, 1'b0, 1'b1, 32'h1234_5678};
        vecs[2]  = '{1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'h1234_5678};
        vecs[3]  = '{1'b1, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0, 1'b0, 1'b1, 32'hA5A5_A5A5};
        vecs[5]  = '{1'b0, 32'h0000_0006, 32'h0, 1'b1, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0100, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[9]  = '{1'b0, 32'hFFFF_FF10, 32'h0, 1'b0, 1'b1, 32'h1111_1111};
        vecs[10] = '{1'b0, 32'h0000_0003, 32'h0, 1'b1, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b1, 32'h1111_1111};

        repeat (3) @(negedge clk);
        chk("rst_ready", ready2, 1);
        chk("rst_done", done2, 0);
        chk("rst_rdata", rdata2, 0);
        chk("rst_err", err2, 0);
        chk("rst_ready3", ready3, 1);
        chk("rst_ready1", ready1, 1);
        reset = 1;

        for (int i = 0; i < 12; i++) begin
            access2(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, e, rd);
            chk($sformatf("v%0d_lat", i), lat, 2);
            chk($sformatf("v%0d_err", i), e, vecs[i].exp_err);
            if (vecs[i].chk_rd) begin
                chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            end
        end

        // Abort a store mid-WAIT with an asynchronous reset.
        @(negedge clk);
        req2 = 1; we2 = 1; addr2 = 32'h10; wdata2 = 32'hDEAD_BEEF;
        @(negedge clk);
        req2 = 0;
        chk("abort_in_wait", ready2, 0);
        reset = 0;
        #1;
        chk("abort_ready", ready2, 1);
        chk("abort_done", done2, 0);
        chk("abort_rdata", rdata2, 0);
        repeat (2) @(negedge clk);
        reset = 1;
        access2(1'b0, 32'h10, 32'h0, lat, e, rd);
        chk("abort_rd_lat", lat, 2);
        chk("abort_rd_data", rd, 32'h1111_1111);

        // LATENCY=3 with req held high: accept every 4 edges.
        @(negedge clk);
        chk("hs_ready0", ready3, 1);
        req3 = 1; we3 = 1; addr3 = 32'h20; wdata3 = 32'h5555_AAAA;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("hs_ready_%0d", i), ready3, 32'((i % 4) == 3));
            chk($sformatf("hs_done_%0d", i), done3, 32'((i % 4) == 2));
            if (done3) begin
                ndone++;
                chk("hs_err", err3, 0);
            end
        end
        req3 = 0;
        chk("hs_ndone", ndone, 3);

        // LATENCY=1: ready low only during the single done cycle.
        @(negedge clk);
        chk("l1_ready0", ready1, 1);
        req1 = 1; we1 = 1; addr1 = 32'h0C; wdata1 = 32'h0BAD_F00D;
        @(negedge clk);
        req1 = 0;
        chk("l1_st_done", done1, 1);
        chk("l1_st_ready", ready1, 0);
        chk("l1_st_err", err1, 0);
        @(negedge clk);
        chk("l1_st_done_end", done1, 0);
        chk("l1_st_ready_back", ready1, 1);
        req1 = 1; we1 = 0; addr1 = 32'h0C;
        @(negedge clk);
        req1 = 0;
        chk("l1_ld_done", done1, 1);
        chk("l1_ld_rdata", rdata1, 32'h0BAD_F00D);
        @(negedge clk);
        chk("l1_ld_done_end", done1, 0);
        chk("l1_ld_hold", rdata1, 32'h0BAD_F00D);
        req1 = 1; we1 = 0; addr1 = 32'h0E;
        @(negedge clk);
        req1 = 0;
        chk("l1_mis_done", done1, 1);
        chk("l1_mis_err", err1, 1);
        chk("l1_mis_rdata", rdata1, 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
